// File: rtl/rtmq_gpr_bank.sv
// Purpose: RTMQ write-back GPR bank; masked Type-A and segmented Type-I writes into N_REG registers.
// Latency: address in cycle t, data in t+1, new value and write strobe visible in cycle t+2.
// Backpressure: none; accepts one write per channel every cycle.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous reset, active-high
//   alu_out  - packed result bus {alu_res, alu_msk, alu_rda, alu_r0a, alu_r1a, imm_res, imm_rda, imm_seg}
//   gpr_bus  - register k at bits [W_REG*(k+1)-1 : W_REG*k]
//   gpr_wse  - per-register one-cycle write-side-effect strobe, aligned with the new value
module rtmq_gpr_bank #(
    parameter int                 W_REG   = 32,
    parameter int                 W_ADR   = 8,
    parameter int                 N_REG   = 8,
    parameter logic [W_ADR-1:0]   A_BASE  = 8'h20,
    parameter logic [W_REG-1:0]   RST_VAL = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*W_REG+4*W_ADR:0]   alu_out,
    output logic [N_REG*W_REG-1:0]     gpr_bus,
    output logic [N_REG-1:0]           gpr_wse
);

    // Field offsets inside alu_out, LSB upward.
    localparam int O_SEG  = 0;
    localparam int O_IRDA = O_SEG + 1;
    localparam int O_IRES = O_IRDA + W_ADR;
    localparam int O_R1A  = O_IRES + W_REG;
    localparam int O_R0A  = O_R1A + W_ADR;
    localparam int O_RDA  = O_R0A + W_ADR;
    localparam int O_MSK  = O_RDA + W_ADR;
    localparam int O_RES  = O_MSK + W_REG;

    // Immediate segment boundary: lower segment is bits [19:0], higher is [31:20].
    localparam int SEG_LO = 20;

    logic [W_REG-1:0] alu_res;
    logic [W_REG-1:0] alu_msk;
    logic [W_ADR-1:0] alu_rda;
    logic [W_REG-1:0] imm_res;
    logic [W_ADR-1:0] imm_rda;
    logic             imm_seg;

    assign alu_res = alu_out[O_RES  +: W_REG];
    assign alu_msk = alu_out[O_MSK  +: W_REG];
    assign alu_rda = alu_out[O_RDA  +: W_ADR];
    assign imm_res = alu_out[O_IRES +: W_REG];
    assign imm_rda = alu_out[O_IRDA +: W_ADR];
    assign imm_seg = alu_out[O_SEG];

    // Source operand addresses travel on the same bus but are not used by write-back.
    logic unused_ok;
    assign unused_ok = ^alu_out[O_R1A +: 2*W_ADR];

    // Address-stage flags, registered so they line up with the data arriving a cycle later.
    logic [N_REG-1:0] f_alu_d, f_alu_q;
    logic [N_REG-1:0] f_imm_d, f_imm_q;
    logic             seg_d, seg_q;

    logic [W_REG-1:0] reg_d [N_REG];
    logic [W_REG-1:0] reg_q [N_REG];
    logic [N_REG-1:0] wse_d, wse_q;

    // Address decode. Zero means "no write"; out-of-bank addresses match nothing.
    always_comb begin
        f_alu_d = '0;
        f_imm_d = '0;
        seg_d   = imm_seg;
        for (int k = 0; k < N_REG; k++) begin
            f_alu_d[k] = (alu_rda != '0) && (alu_rda == W_ADR'(A_BASE + k));
            f_imm_d[k] = (imm_rda != '0) && (imm_rda == W_ADR'(A_BASE + k));
        end
    end

    // Data stage. The immediate segment is merged first so a colliding ALU
    // masked write lands on top of it: R' = alu_res | (Rimm & alu_msk).
    logic [W_REG-1:0] r_imm;

    always_comb begin
        r_imm = '0;
        wse_d = '0;
        for (int k = 0; k < N_REG; k++) begin
            r_imm = reg_q[k];
            if (f_imm_q[k]) begin
                if (seg_q) begin
                    r_imm[SEG_LO-1:0] = imm_res[SEG_LO-1:0];
                end else begin
                    r_imm[W_REG-1:SEG_LO] = imm_res[W_REG-1:SEG_LO];
                end
            end
            reg_d[k] = f_alu_q[k] ? (alu_res | (r_imm & alu_msk)) : r_imm;
            // Strobe on every decoded write, even if the value does not change.
            wse_d[k] = f_alu_q[k] | f_imm_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_alu_q <= '0;
            f_imm_q <= '0;
            seg_q   <= 1'b0;
            wse_q   <= '0;
            for (int k = 0; k < N_REG; k++) begin
                reg_q[k] <= RST_VAL;
            end
        end else begin
            f_alu_q <= f_alu_d;
            f_imm_q <= f_imm_d;
            seg_q   <= seg_d;
            wse_q   <= wse_d;
            for (int k = 0; k < N_REG; k++) begin
                reg_q[k] <= reg_d[k];
            end
        end
    end

    for (genvar k = 0; k < N_REG; k++) begin : g_bus
        assign gpr_bus[W_REG*k +: W_REG] = reg_q[k];
    end

    assign gpr_wse = wse_q;

endmodule

// File: doc/rtmq_gpr_bank.md
Name: rtmq_gpr_bank

Overview:
- Write-back stage directly downstream of the RTMQ ALU. Consumes the packed ALU/immediate result bus.
- Holds N_REG general-purpose registers at consecutive addresses A_BASE..A_BASE+N_REG-1.
- Applies masked Type-A writes and segmented Type-I writes.
- Drives the register values back onto the shared regfile bus, plus a per-register write-side-effect strobe.

Parameters:
- W_REG, 32: register width; must be 32 (segment split 20/12 is fixed).
- W_ADR, 8: register address width.
- N_REG, 8: number of registers in the bank (1..64).
- A_BASE, 8'h20: address of register 0 of the bank; must be nonzero, and A_BASE+N_REG-1 must be at most 2^W_ADR-1.
- RST_VAL, 32'h0: reset value of every register.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-high.
- alu_out, input, 3*W_REG+4*W_ADR+1: packed bus, MSB first: {alu_res, alu_msk, alu_rda, alu_r0a, alu_r1a, imm_res, imm_rda, imm_seg}. alu_r0a and alu_r1a are ignored.
- gpr_bus, output, N_REG*W_REG: register k at bits [W_REG*(k+1)-1 : W_REG*k].
- gpr_wse, output, N_REG: register k write-side-effect strobe.

Behaviour:
Reset:
- All registers = RST_VAL; gpr_wse = 0; all internal flags = 0. Effect is immediate (asynchronous).
- Writes pending in flight are discarded; no write occurs on the first edge after rst deasserts.

Address 0:
- Means "no write" on both channels, and is never decoded.
- Addresses outside the bank range are ignored.

A channel timing:
- alu_rda is valid one cycle before alu_res/alu_msk.
- Stage: f_alu[k] <= (alu_rda == A_BASE+k), registered.
- Next edge, if f_alu[k]: R[k] <= alu_res | (R[k] & alu_msk).
- Result: alu_rda in cycle t -> new value on gpr_bus in cycle t+2.

I channel timing:
- imm_rda/imm_seg are combinational in cycle t; imm_res is valid in cycle t+1.
- Register both: f_imm[k] <= (imm_rda == A_BASE+k); d_seg <= imm_seg.
- Next edge, if f_imm[k]:
  - d_seg=1 (lower): R[k][19:0] <= imm_res[19:0]; bits 31:20 unchanged.
  - d_seg=0 (higher): R[k][31:20] <= imm_res[31:20]; bits 19:0 unchanged.
- Result: new value visible in cycle t+2.

Collision:
- A and I writes land on the same register at the same edge: apply the immediate segment first, then the ALU masked write on top.
- Effectively R' = alu_res | (Rimm & alu_msk), where Rimm is R with the segment replaced.
- Writes to different registers at the same edge both take effect.

gpr_wse[k]:
- Registered; high for exactly one cycle, the same cycle the new value first appears on gpr_bus.
- Asserted for every decoded write, including a write of an unchanged value or with an all-ones alu_msk.
- Back-to-back writes every cycle keep it high continuously.

General:
- No throughput limit; one write per channel per cycle.
- gpr_bus is a direct register output with no combinational path from alu_out.

Test Plan:
1. Reset:
   - Assert rst mid-stream with a pending A write to 0x20 (alu_rda sent the cycle before).
   - Expect all of gpr_bus = 0 immediately, no wse, R0 still 0 after release.
2. Full ALU write:
   - alu_rda=0x21 at cycle t; alu_res=0xDEADBEEF, alu_msk=0 at t+1.
   - Expect R1=0xDEADBEEF and gpr_wse=8'b00000010 at t+2 only.
3. Masked write:
   - R2=0x12345678; write alu_res=0x0000AB00, alu_msk=0xFFFF00FF.
   - Expect R2=0x1234AB78.
4. Segmented immediates:
   - Lower imm 0xABCDE then higher imm 0x123 to 0x23, issued on consecutive cycles.
   - Expect R3=0x000ABCDE at t+2, then 0x123ABCDE at t+3, wse[3] high for 2 cycles.
5. Collision:
   - Same edge: higher imm 0xFFF and ALU write alu_res=0x000000AA, alu_msk=0xFFFFFF00 to 0x24 (R4 initially 0).
   - Expect R4=0xFFF000AA.
6. Out of range:
   - alu_rda=0x00, 0x1F, 0x28; imm_rda=0x28.
   - Expect no register change and gpr_wse=0 throughout.
